uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter DIVISION, default 867, bit period in clock cycles minus 1 (bit period = DIVISION+1 cycles).
REQ-002 Parameter TIMEOUT_BITS, default 32, maximum gap between bytes of one command, in bit periods.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous active-low reset: state is reset on any rising clk edge where reset=0.
REQ-005 rx  input  1  serial command input, asynchronous, idle high.
REQ-006 tx  output  1  serial response output, idle high.
REQ-007 valid  output  1  bus request.
REQ-008 ready  input  1  bus responder completion.
REQ-009 address  output  32  bus byte address.
REQ-010 wstrobe  output  4  byte write enables; 0 = read.
REQ-011 wdata  output  32  bus write data.
REQ-012 rdata  input  32  bus read data, valid when valid && ready.
REQ-013 busy  output  1  high whenever the command FSM is not in CMD.

Function
REQ-014 rx SHALL pass a 2-flop synchronizer; all receive logic uses the synchronized value.
REQ-015 Frame format, both directions: start 0, 8 data bits LSB first, stop 1; no parity.
REQ-016 Receiver SHALL detect start on synchronized rx=0 while idle, then sample each bit when its per-bit down-counter (loaded with DIVISION) equals DIVISION/2 (integer division).
REQ-017 Start bit sampled 1 at mid-bit SHALL abort the frame (glitch) and return the receiver to idle.
REQ-018 Stop bit sampled 0 SHALL discard the byte and force the command FSM to CMD (resync).
REQ-019 Transmitter SHALL drive each bit for exactly DIVISION+1 cycles; a frame is 10*(DIVISION+1) cycles; tx=1 when idle.
REQ-020 Command FSM states: CMD, ADDR, DATA, BUS, RESP.
REQ-021 CMD: byte 0x01 -> write, 0x02 -> read; both go to ADDR; any other byte -> RESP sending single byte 0x15 (NAK).
REQ-022 ADDR: collect 4 bytes little-endian into address; then write -> DATA, read -> BUS.
REQ-023 DATA: collect 4 bytes little-endian into wdata; then -> BUS.
REQ-024 BUS: assert valid the cycle after entry; wstrobe=4'b1111 for write, 4'b0000 for read; address/wdata/wstrobe stable while valid=1.
REQ-025 Transfer completes on the first edge with valid && ready; valid SHALL be 0 the following cycle; read captures rdata on that edge.
REQ-026 No bus timeout: valid stays high indefinitely until ready.
REQ-027 RESP: write sends one byte 0x06 (ACK); read sends 4 bytes rdata little-endian, back-to-back (next start bit immediately after previous stop bit); then -> CMD.
REQ-028 Bytes arriving on rx during BUS or RESP SHALL be discarded.
REQ-029 In ADDR or DATA, if no new start bit within TIMEOUT_BITS*(DIVISION+1) cycles after the previous stop bit, FSM SHALL return to CMD with no response and no bus transfer.
REQ-030 busy=1 from the cycle after a valid command byte's stop sample through the cycle the last response stop bit ends.

Reset
REQ-031 Reset SHALL force: tx=1, valid=0, address=0, wdata=0, wstrobe=0, busy=0, FSM=CMD, receiver and transmitter idle, synchronizer flops=1.
REQ-032 Reset asserted mid-frame or mid-transfer SHALL abort immediately; no partial response is sent after reset release; valid drops on the reset edge.
REQ-033 First start bit is recognized no earlier than 2 cycles after reset release (synchronizer latency).

Verification
REQ-034 DIVISION=3; send 01, 10 00 00 00, EF BE AD DE; ready tied 1 -> one valid pulse with address=0x00000010, wdata=0xDEADBEEF, wstrobe=0xF; tx returns 0x06.
REQ-035 Send 02, 04 00 00 00; ready asserted 5 cycles after valid, rdata=0x12345678 -> valid high 6 cycles, wstrobe=0; tx returns 78 56 34 12 back-to-back.
REQ-036 Send 0x7F -> tx returns 0x15, no valid, busy returns 0.
REQ-037 Send 01, 10 00, then idle 40 bit periods (TIMEOUT_BITS=32) -> no valid, busy=0; subsequent 02 read command works normally.
REQ-038 Frame with stop bit 0 during ADDR -> FSM to CMD, no bus transfer; 1-cycle rx low glitch while idle -> no byte received.
REQ-039 Assert reset during the 2nd response byte of a read -> tx=1 and valid=0 from reset edge; no further tx activity until a new command.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: serial commands (write 0x01 / read 0x02) drive a single-beat
// 32-bit bus transfer, and the result goes back over tx as ACK/NAK or read data.
module uart_bus_master #(
    parameter int DIVISION     = 867,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        valid,
    input  logic        ready,
    output logic [31:0] address,
    output logic [3:0]  wstrobe,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    localparam int CNT_W = (DIVISION < 2) ? 1 : $clog2(DIVISION + 1);
    localparam logic [CNT_W-1:0] DIV_VAL  = CNT_W'(DIVISION);
    localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'(DIVISION / 2);
    localparam int TMO_LIMIT = TIMEOUT_BITS * (DIVISION + 1);
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_LIMIT);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_CMD  = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic             rxMeta_q, rxSync_q;
    logic [1:0]       rxState_q, rxState_d;
    logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]       rxBit_q, rxBit_d;
    logic [7:0]       rxShift_q, rxShift_d;
    logic             rxDone, rxErr, midBit, endBit;

    logic [2:0]       state_q, state_d;
    logic             isWrite_q, isWrite_d;
    logic [1:0]       byteCnt_q, byteCnt_d;
    logic [31:0]      address_q, address_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrobe_q, wstrobe_d;
    logic             valid_q, valid_d;
    logic [31:0]      respBuf_q, respBuf_d;
    logic [2:0]       respLeft_q, respLeft_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             txActive_q, txActive_d;
    logic [8:0]       txShift_q, txShift_d;
    logic [3:0]       txBits_q, txBits_d;
    logic [CNT_W-1:0] txCnt_q, txCnt_d;
    logic             tx_q, tx_d;
    logic             txLoad;

    // Receiver: each bit is sampled once, when its down-counter passes the middle value.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q;
        rxBit_d   = rxBit_q;
        rxShift_d = rxShift_q;
        rxDone    = 1'b0;
        rxErr     = 1'b0;
        midBit    = (rxCnt_q == HALF_VAL);
        endBit    = (rxCnt_q == '0);
        if (rxState_q != RX_IDLE) begin
            rxCnt_d = endBit ? DIV_VAL : rxCnt_q - CNT_W'(1);
        end
        case (rxState_q)
            RX_IDLE: begin
                if (!rxSync_q) begin
                    rxState_d = RX_START;
                    rxCnt_d   = DIV_VAL;
                end
            end
            RX_START: begin
                if (midBit && rxSync_q) begin
                    rxState_d = RX_IDLE;
                end else if (endBit) begin
                    rxState_d = RX_DATA;
                    rxBit_d   = 3'd0;
                end
            end
            RX_DATA: begin
                if (midBit) begin
                    rxShift_d = {rxSync_q, rxShift_q[7:1]};
                end
                if (endBit) begin
                    if (rxBit_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end
                    rxBit_d = rxBit_q + 3'd1;
                end
            end
            RX_STOP: begin
                // Returning to idle at mid-stop lets a back-to-back start bit be caught.
                if (midBit) begin
                    rxState_d = RX_IDLE;
                    rxDone    = rxSync_q;
                    rxErr     = !rxSync_q;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        isWrite_d  = isWrite_q;
        byteCnt_d  = byteCnt_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        wstrobe_d  = wstrobe_q;
        valid_d    = valid_q;
        respBuf_d  = respBuf_q;
        respLeft_d = respLeft_q;
        txActive_d = txActive_q;
        txShift_d  = txShift_q;
        txBits_d   = txBits_q;
        txCnt_d    = txCnt_q;
        tx_d       = tx_q;
        txLoad     = 1'b0;

        // Transmitter; a pending response byte is loaded on the very edge the stop bit ends.
        if (txActive_q) begin
            if (txCnt_q == '0) begin
                txCnt_d = DIV_VAL;
                if (txBits_q == 4'd0) begin
                    if (respLeft_q != 3'd0) begin
                        txLoad = 1'b1;
                    end else begin
                        txActive_d = 1'b0;
                        tx_d       = 1'b1;
                        if (state_q == ST_RESP) begin
                            state_d = ST_CMD;
                        end
                    end
                end else begin
                    tx_d      = txShift_q[0];
                    txShift_d = {1'b1, txShift_q[8:1]};
                    txBits_d  = txBits_q - 4'd1;
                end
            end else begin
                txCnt_d = txCnt_q - CNT_W'(1);
            end
        end else if (state_q == ST_RESP && respLeft_q != 3'd0) begin
            txLoad = 1'b1;
        end
        if (txLoad) begin
            tx_d       = 1'b0;
            txShift_d  = {1'b1, respBuf_q[7:0]};
            txBits_d   = 4'd9;
            txCnt_d    = DIV_VAL;
            txActive_d = 1'b1;
            respBuf_d  = {8'h00, respBuf_q[31:8]};
            respLeft_d = respLeft_q - 3'd1;
        end

        tmo_d = '0;
        if ((state_q == ST_ADDR || state_q == ST_DATA) && rxState_q == RX_IDLE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_CMD: begin
                if (rxDone) begin
                    byteCnt_d = 2'd0;
                    if (rxShift_q == 8'h01 || rxShift_q == 8'h02) begin
                        isWrite_d = (rxShift_q == 8'h01);
                        state_d   = ST_ADDR;
                    end else begin
                        respBuf_d  = 32'h0000_0015;
                        respLeft_d = 3'd1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (rxErr || (!rxDone && tmo_q == TMO_MAX)) begin
                    state_d = ST_CMD;
                end else if (rxDone) begin
                    address_d = {rxShift_q, address_q[31:8]};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        if (isWrite_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d   = ST_BUS;
                            valid_d   = 1'b1;
                            wstrobe_d = 4'b0000;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rxErr || (!rxDone && tmo_q == TMO_MAX)) begin
                    state_d = ST_CMD;
                end else if (rxDone) begin
                    wdata_d   = {rxShift_q, wdata_q[31:8]};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        state_d   = ST_BUS;
                        valid_d   = 1'b1;
                        wstrobe_d = 4'b1111;
                    end
                end
            end
            ST_BUS: begin
                if (valid_q && ready) begin
                    valid_d    = 1'b0;
                    wstrobe_d  = 4'b0000;
                    state_d    = ST_RESP;
                    respBuf_d  = isWrite_q ? 32'h0000_0006 : rdata;
                    respLeft_d = isWrite_q ? 3'd1 : 3'd4;
                end
            end
            ST_RESP: begin
            end
            default: state_d = ST_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            rxState_q  <= RX_IDLE;
            rxCnt_q    <= '0;
            rxBit_q    <= 3'd0;
            rxShift_q  <= 8'h00;
            state_q    <= ST_CMD;
            isWrite_q  <= 1'b0;
            byteCnt_q  <= 2'd0;
            address_q  <= 32'h0;
            wdata_q    <= 32'h0;
            wstrobe_q  <= 4'b0000;
            valid_q    <= 1'b0;
            respBuf_q  <= 32'h0;
            respLeft_q <= 3'd0;
            tmo_q      <= '0;
            txActive_q <= 1'b0;
            txShift_q  <= 9'h1FF;
            txBits_q   <= 4'd0;
            txCnt_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            rxMeta_q   <= rx;
            rxSync_q   <= rxMeta_q;
            rxState_q  <= rxState_d;
            rxCnt_q    <= rxCnt_d;
            rxBit_q    <= rxBit_d;
            rxShift_q  <= rxShift_d;
            state_q    <= state_d;
            isWrite_q  <= isWrite_d;
            byteCnt_q  <= byteCnt_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            wstrobe_q  <= wstrobe_d;
            valid_q    <= valid_d;
            respBuf_q  <= respBuf_d;
            respLeft_q <= respLeft_d;
            tmo_q      <= tmo_d;
            txActive_q <= txActive_d;
            txShift_q  <= txShift_d;
            txBits_q   <= txBits_d;
            txCnt_q    <= txCnt_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign valid   = valid_q;
    assign address = address_q;
    assign wdata   = wdata_q;
    assign wstrobe = wstrobe_q;
    assign busy    = (state_q != ST_CMD);

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: serial commands in, bus and tx responses
// checked against queued expectations.
module tb_uart_bus_master;

    localparam int DIV = 3;
    localparam int BIT = DIV + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } busTxn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        tx;
    logic        valid;
    logic        ready;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCnt = 0;
    int validPulses = 0;
    int lastValidLen = 0;
    int readyMode = 0;
    bit monEn = 1'b1;

    logic [7:0] txExp[$];
    busTxn_t    busExp[$];
    int         txStarts[$];

    uart_bus_master #(.DIVISION(DIV), .TIMEOUT_BITS(32)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .valid(valid), .ready(ready),
        .address(address), .wstrobe(wstrobe), .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt++;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one serial frame; stopVal=0 produces a framing error.
    task automatic applyStimulus(input logic [7:0] b, input logic stopVal = 1'b1);
        logic [9:0] frame;
        frame = {stopVal, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n;
        n = 0;
        while ((txExp.size() != 0 || busy !== 1'b0) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(n < maxCycles), 64'd1);
    endtask

    // tx decoder: samples 1.5 cycles into each bit and scores against txExp.
    initial begin
        logic [7:0] d;
        logic s0, sp;
        forever begin
            @(negedge clk);
            if (monEn && tx === 1'b0) begin
                txStarts.push_back(cycleCnt);
                @(negedge clk);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                sp = tx;
                if (monEn) begin
                    checkOutput("tx byte was expected", 64'(txExp.size() > 0), 64'd1);
                    if (txExp.size() > 0) begin
                        checkOutput("tx frame", 64'({sp, d, s0}), 64'({1'b1, txExp.pop_front(), 1'b0}));
                    end
                end
            end
        end
    end

    // Bus monitor and ready driver (mode 0: tied high, 1: after 6 valid cycles, 2: never).
    initial begin
        busTxn_t cur, e;
        logic prevValid;
        int vc;
        bit unstable;
        prevValid = 1'b0;
        vc = 0;
        unstable = 1'b0;
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (!prevValid) begin
                    vc = 0;
                    unstable = 1'b0;
                    validPulses++;
                    cur = {address, wdata, wstrobe};
                    checkOutput("bus transfer was expected", 64'(busExp.size() > 0), 64'd1);
                    if (busExp.size() > 0) begin
                        e = busExp.pop_front();
                        checkOutput("bus address", 64'(address), 64'(e.addr));
                        checkOutput("bus wstrobe", 64'(wstrobe), 64'(e.strb));
                        if (e.strb != 4'b0000) checkOutput("bus wdata", 64'(wdata), 64'(e.data));
                    end
                end else if ({address, wdata, wstrobe} !== cur) begin
                    unstable = 1'b1;
                end
                vc++;
            end else if (prevValid) begin
                lastValidLen = vc;
                checkOutput("bus stable while valid", 64'(unstable), 64'd0);
            end
            prevValid = valid;
            ready = (readyMode == 0) ? 1'b1 : (readyMode == 1 && valid === 1'b1 && vc >= 6);
        end
    end

    initial begin
        int pulses0, lows, n;
        reset = 1'b0;
        rx = 1'b1;
        rdata = 32'h1234_5678;
        repeat (4) @(negedge clk);
        checkOutput("reset tx", 64'(tx), 64'd1);
        checkOutput("reset valid", 64'(valid), 64'd0);
        checkOutput("reset address", 64'(address), 64'd0);
        checkOutput("reset wdata", 64'(wdata), 64'd0);
        checkOutput("reset wstrobe", 64'(wstrobe), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Write with ready tied high
        pulses0 = validPulses;
        busExp.push_back({32'h0000_0010, 32'hDEAD_BEEF, 4'hF});
        txExp.push_back(8'h06);
        applyStimulus(8'h01);
        applyStimulus(8'h10);
        checkOutput("busy during command", 64'(busy), 64'd1);
        applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
        waitIdle(400, "write completes");
        checkOutput("write valid pulses", 64'(validPulses - pulses0), 64'd1);
        checkOutput("write valid length", 64'(lastValidLen), 64'd1);

        // Read with ready delayed, four back-to-back response bytes
        readyMode = 1;
        txStarts.delete();
        busExp.push_back({32'h0000_0004, 32'h0, 4'h0});
        txExp.push_back(8'h78); txExp.push_back(8'h56); txExp.push_back(8'h34); txExp.push_back(8'h12);
        applyStimulus(8'h02);
        applyStimulus(8'h04); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        waitIdle(800, "read completes");
        checkOutput("read valid length", 64'(lastValidLen), 64'd6);
        checkOutput("read tx byte count", 64'(txStarts.size()), 64'd4);
        for (int i = 1; i < txStarts.size(); i++) begin
            checkOutput("read back-to-back gap", 64'(txStarts[i] - txStarts[i-1]), 64'(10 * BIT));
        end

        // Unknown command gets NAK
        readyMode = 0;
        pulses0 = validPulses;
        txExp.push_back(8'h15);
        applyStimulus(8'h7F);
        waitIdle(400, "nak completes");
        checkOutput("nak no valid", 64'(validPulses - pulses0), 64'd0);
        checkOutput("nak busy low", 64'(busy), 64'd0);

        // Inter-byte timeout in ADDR, then a normal read
        applyStimulus(8'h01); applyStimulus(8'h10); applyStimulus(8'h00);
        repeat (100) @(negedge clk);
        checkOutput("busy before timeout", 64'(busy), 64'd1);
        repeat (60) @(negedge clk);
        checkOutput("busy after timeout", 64'(busy), 64'd0);
        checkOutput("timeout no valid", 64'(validPulses - pulses0), 64'd0);
        rdata = 32'hCAFE_F00D;
        busExp.push_back({32'h0000_0080, 32'h0, 4'h0});
        txExp.push_back(8'h0D); txExp.push_back(8'hF0); txExp.push_back(8'hFE); txExp.push_back(8'hCA);
        applyStimulus(8'h02);
        applyStimulus(8'h80); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        waitIdle(800, "read after timeout completes");

        // Framing error during ADDR, then a one-cycle glitch while idle
        pulses0 = validPulses;
        applyStimulus(8'h01); applyStimulus(8'h10);
        applyStimulus(8'h00, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("framing error busy low", 64'(busy), 64'd0);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("glitch busy low", 64'(busy), 64'd0);
        checkOutput("framing and glitch no valid", 64'(validPulses - pulses0), 64'd0);

        // Reset in the middle of the second read response byte
        rdata = 32'h1234_5678;
        busExp.push_back({32'h0000_0040, 32'h0, 4'h0});
        txExp.push_back(8'h78);
        applyStimulus(8'h02);
        applyStimulus(8'h40); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        n = 0;
        while (txExp.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first response byte seen", 64'(n < 400), 64'd1);
        repeat (10) @(negedge clk);
        monEn = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset mid response tx", 64'(tx), 64'd1);
        checkOutput("reset mid response busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checkOutput("tx silent after reset", 64'(lows), 64'd0);
        monEn = 1'b1;

        // Reset while valid is waiting on ready
        readyMode = 2;
        busExp.push_back({32'h0000_0020, 32'h1122_3344, 4'hF});
        applyStimulus(8'h01);
        applyStimulus(8'h20); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h44); applyStimulus(8'h33); applyStimulus(8'h22); applyStimulus(8'h11);
        n = 0;
        while (valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid raised awaiting ready", 64'(valid), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset drops valid", 64'(valid), 64'd0);
        checkOutput("reset during bus tx", 64'(tx), 64'd1);
        reset = 1'b1;
        readyMode = 0;
        repeat (100) @(negedge clk);
        checkOutput("no response after bus reset", 64'(busy), 64'd0);

        // Normal write after reset
        busExp.push_back({32'h0000_0100, 32'hA5A5_5A5A, 4'hF});
        txExp.push_back(8'h06);
        applyStimulus(8'h01);
        applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00);
        applyStimulus(8'h5A); applyStimulus(8'h5A); applyStimulus(8'hA5); applyStimulus(8'hA5);
        waitIdle(400, "write after reset completes");
        checkOutput("bus queue drained", 64'(busExp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
